// File: rtl/shift_in_reader.sv
// Scans a 74HC165-style PISO chain over GPIO: parallel-loads it, clocks out NBITS bits,
// and publishes the button word plus a mask of buttons newly pressed since the last scan.
//
// state  | meaning
// IDLE   | outputs idle, gap counter runs, waits for gap satisfied and EN on a tick
// LOAD   | SR_LD_N low for one tick interval
// LOW    | SR_CLK low; on tick sample SR_DIN and raise SR_CLK
// HIGH   | SR_CLK high; on tick lower SR_CLK, next bit or finish
// DONE   | one cycle: publish DATA/PRESS, pulse VALID
module shift_in_reader #(
    parameter int DIV    = 4,
    parameter int NBITS  = 8,
    parameter int GAP    = 16,
    parameter int INVERT = 1
) (
    input  logic             CLK1_50,
    input  logic             CLR,
    input  logic             EN,
    input  logic             SR_DIN,
    output logic             SR_LD_N,
    output logic             SR_CLK,
    output logic [NBITS-1:0] DATA,
    output logic             VALID,
    output logic [NBITS-1:0] PRESS
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IW = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(NBITS - 1);
    localparam logic [GW-1:0]    GAP_L    = GW'(GAP);
    localparam logic [NBITS-1:0] INV_MASK = (INVERT != 0) ? {NBITS{1'b1}} : {NBITS{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [DW-1:0]    div_q;
    logic [DW-1:0]    div_d;
    logic             tick;
    logic [GW-1:0]    gap_q;
    logic [IW-1:0]    idx_q;
    logic [NBITS-1:0] cap_q;
    logic [NBITS-1:0] word_d;
    logic             sr_ld_n_q;
    logic             sr_clk_q;
    logic [NBITS-1:0] data_q;
    logic [NBITS-1:0] press_q;
    logic             valid_q;

    always_comb begin
        tick   = (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + DW'(1);
        word_d = cap_q ^ INV_MASK;
    end

    always_ff @(posedge CLK1_50) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            cap_q     <= '0;
            sr_ld_n_q <= 1'b1;
            sr_clk_q  <= 1'b0;
            data_q    <= '0;
            press_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        // Saturating, so a long EN-low wait still launches on the next tick.
                        if (gap_q < GAP_L) gap_q <= gap_q + GW'(1);
                        if (EN && (gap_q >= GAP_L)) begin
                            sr_ld_n_q <= 1'b0;
                            state_q   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (tick) begin
                        sr_ld_n_q <= 1'b1;
                        idx_q     <= '0;
                        state_q   <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (tick) begin
                        cap_q    <= {cap_q[NBITS-2:0], SR_DIN};
                        sr_clk_q <= 1'b1;
                        state_q  <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (tick) begin
                        sr_clk_q <= 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= S_LOW;
                        end
                    end
                end
                S_DONE: begin
                    data_q  <= word_d;
                    press_q <= word_d & ~data_q;
                    valid_q <= 1'b1;
                    gap_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SR_LD_N = sr_ld_n_q;
    assign SR_CLK  = sr_clk_q;
    assign DATA    = data_q;
    assign PRESS   = press_q;
    assign VALID   = valid_q;

endmodule

// File: tb/tb_shift_in_reader.sv
// Bench for shift_in_reader: two instances (INVERT=0 / INVERT=1) each driving a 74HC165 model;
// expected words go into a scoreboard queue and a negedge monitor checks every VALID.
module tb_shift_in_reader;

    localparam int DIV = 4;
    localparam int NB  = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en      [2];
    logic       sr_din  [2];
    logic       sr_ld_n [2];
    logic       sr_clk  [2];
    logic [7:0] data    [2];
    logic [7:0] press   [2];
    logic       valid   [2];

    logic [7:0] par_in  [2];
    logic [7:0] sr_reg  [2];
    logic       clk_prev[2];
    logic       force_tog = 1'b1;
    logic       tog = 1'b0;
    logic       mon_en = 1'b0;

    int total = 0;
    int bad   = 0;
    int ld_len[2];
    int rises [2];
    int lds   [2];
    int vcnt  [2];
    logic prev_ld [2];
    logic prev_clk[2];

    // entry = {instance, expected DATA, expected PRESS}
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        shift_in_reader #(.DIV(DIV), .NBITS(NB), .GAP(16), .INVERT(g)) u_dut (
            .CLK1_50(clk),
            .CLR    (clr),
            .EN     (en[g]),
            .SR_DIN (sr_din[g]),
            .SR_LD_N(sr_ld_n[g]),
            .SR_CLK (sr_clk[g]),
            .DATA   (data[g]),
            .VALID  (valid[g]),
            .PRESS  (press[g])
        );
    end

    // 165 model: QH = bit 7; parallel load while LD_N low, shift toward QH on SR_CLK rise.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            clk_prev[g] <= sr_clk[g];
            if (!sr_ld_n[g]) sr_reg[g] <= par_in[g];
            else if (sr_clk[g] && !clk_prev[g]) sr_reg[g] <= {sr_reg[g][6:0], 1'b0};
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) sr_din[g] = force_tog ? tog : sr_reg[g][7];
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (mon_en) begin
            for (int g = 0; g < 2; g++) begin
                chk("ld_during_clk_high", int'(!sr_ld_n[g] && sr_clk[g]), 0);
                if (!sr_ld_n[g]) begin
                    ld_len[g]++;
                    rises[g] = 0;
                    if (prev_ld[g]) lds[g]++;
                end else if (!prev_ld[g]) begin
                    chk("ld_low_cycles", ld_len[g], DIV);
                    ld_len[g] = 0;
                end
                if (sr_clk[g] && !prev_clk[g]) rises[g]++;
                if (valid[g]) begin
                    vcnt[g]++;
                    chk("clk_rises_per_frame", rises[g], NB);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("valid_instance", g, int'(e[16]));
                        chk("data", int'(data[g]), int'(e[15:8]));
                        chk("press", int'(press[g]), int'(e[7:0]));
                    end
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            prev_ld[g]  = sr_ld_n[g];
            prev_clk[g] = sr_clk[g];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int g, input string name);
        int s = vcnt[g];
        int n = 0;
        while (vcnt[g] == s && n < 2000) begin step(); n++; end
        chk(name, int'(vcnt[g] != s), 1);
    endtask

    task automatic wait_ld_fall(input int g);
        int s = lds[g];
        int n = 0;
        while (lds[g] == s && n < 2000) begin step(); n++; end
        chk("frame_start_timeout", int'(lds[g] != s), 1);
    endtask

    task automatic wait_rises(input int g, input int k);
        int n = 0;
        while (rises[g] < k && n < 2000) begin step(); n++; end
        chk("rise_wait_timeout", int'(rises[g] >= k), 1);
    endtask

    task automatic chk_reset_outputs(input int g);
        chk("rst_ld_n", int'(sr_ld_n[g]), 1);
        chk("rst_sr_clk", int'(sr_clk[g]), 0);
        chk("rst_data", int'(data[g]), 0);
        chk("rst_press", int'(press[g]), 0);
        chk("rst_valid", int'(valid[g]), 0);
    endtask

    task automatic frame(input int g, input logic [7:0] par, input logic [7:0] ed,
                         input logic [7:0] ep);
        par_in[g] = par;
        exp_q.push_back({g[0], ed, ep});
        wait_valid(g, "valid_timeout");
    endtask

    initial begin
        int n;
        int viol;
        for (int g = 0; g < 2; g++) begin
            en[g] = 1'b0; par_in[g] = 8'h00;
            ld_len[g] = 0; rises[g] = 0; lds[g] = 0; vcnt[g] = 0;
        end

        // Reset held 5 cycles with SR_DIN toggling
        for (int i = 0; i < 5; i++) begin
            step();
            tog = ~tog;
            chk_reset_outputs(0);
            chk_reset_outputs(1);
        end
        clr = 1'b0;
        force_tog = 1'b0;
        mon_en = 1'b1;

        // INVERT=0 sequences
        en[0] = 1'b1;
        frame(0, 8'hA5, 8'hA5, 8'hA5);
        frame(0, 8'h00, 8'h00, 8'h00);
        frame(0, 8'h81, 8'h81, 8'h81);
        frame(0, 8'h01, 8'h01, 8'h00);
        en[0] = 1'b0;

        // INVERT=1: active-low board, FE means only bit 0 pressed
        en[1] = 1'b1;
        frame(1, 8'hFE, 8'h01, 8'h01);
        frame(1, 8'hFE, 8'h01, 8'h00);
        en[1] = 1'b0;

        // EN dropped in 3rd LOW phase: frame still completes and reports
        par_in[0] = 8'h3C;
        exp_q.push_back({1'b0, 8'h3C, 8'h3C});
        en[0] = 1'b1;
        wait_ld_fall(0);
        wait_rises(0, 2);
        n = 0;
        while (sr_clk[0] && n < 100) begin step(); n++; end
        en[0] = 1'b0;
        wait_valid(0, "valid_after_en_drop");
        viol = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (!sr_ld_n[0] || sr_clk[0]) viol++;
        end
        chk("idle_while_en_low", viol, 0);
        exp_q.push_back({1'b0, 8'h3C, 8'h00});
        en[0] = 1'b1;
        n = 0;
        while (sr_ld_n[0] && n < 100) begin step(); n++; end
        chk("load_latency_after_en", int'(n >= 1 && n <= DIV), 1);
        wait_valid(0, "valid_after_en_raise");

        // CLR pulse in 5th HIGH phase aborts the frame
        par_in[0] = 8'hA5;
        wait_ld_fall(0);
        wait_rises(0, 5);
        chk("in_high_before_clr", int'(sr_clk[0]), 1);
        clr = 1'b1;
        step();
        chk_reset_outputs(0);
        clr = 1'b0;
        exp_q.push_back({1'b0, 8'hA5, 8'hA5});
        wait_valid(0, "valid_after_clr");
        en[0] = 1'b0;

        for (int i = 0; i < 10; i++) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/shift_in_reader.md
# shift_in_reader

Serial-input reader for the snake game box's button board: drives parallel-load and shift clock to an external PISO shift register (74HC165-style) over GPIO, deserializes its output into a parallel button word, and reports newly pressed buttons. It is the input-side counterpart of the GPIO shift-register driver that clocks LED data out. It runs free-running scans so the game logic always sees a fresh, stable button snapshot.

## Interface
- DIV, 4: system clocks per tick (one SR phase); legal ≥ 2.
- NBITS, 8: bits per frame (register chain length).
- GAP, 16: idle ticks between frames; legal ≥ 0.
- INVERT, 1: 1 = board buttons are active-low; captured bits are inverted so DATA bit = 1 means pressed.

- CLK1_50  in  1  system clock, 50 MHz; all logic on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- EN  in  1  scan enable; sampled only in IDLE.
- SR_DIN  in  1  serial data from register QH (GPIO input, pre-synchronized externally by 2 flops).
- SR_LD_N  out  1  parallel load to register, active-low.
- SR_CLK  out  1  shift clock to register; shifts on its rising edge.
- DATA  out  NBITS  last complete button word; first bit shifted in lands in DATA[NBITS-1].
- VALID  out  1  one-cycle pulse when DATA/PRESS update.
- PRESS  out  NBITS  bits that went 0→1 in DATA at the last update; held until next update.

## Operation
- Tick generator: counter 0..DIV-1, tick asserted the cycle count = DIV-1; counter cleared by CLR. All state transitions except DONE occur only on tick.
- States: IDLE, LOAD, LOW, HIGH, DONE.
- IDLE: SR_LD_N=1, SR_CLK=0. Gap counter increments per tick; when gap count ≥ GAP and EN=1 on a tick → LOAD. EN=0 holds IDLE (gap counter saturates).
- LOAD: SR_LD_N=0 for exactly one tick interval (DIV cycles). On tick → LOW, bit index = 0, SR_LD_N=1.
- LOW: SR_CLK=0. On tick: shift SR_DIN into capture register (MSB-first, capture = {capture[NBITS-2:0], SR_DIN}), SR_CLK←1 → HIGH.
- HIGH: SR_CLK=1. On tick: SR_CLK←0; if index = NBITS-1 → DONE, else index+1 → LOW.
- DONE (one cycle, not tick-gated): new = capture XOR {NBITS{INVERT}}; DATA←new; PRESS←new & ~DATA(old); VALID=1; gap counter←0 → IDLE.
- EN is ignored once LOAD is entered: a started frame always completes and reports.
- Exactly NBITS rising SR_CLK edges per frame; SR_LD_N never low while SR_CLK high.
- Release events (1→0) are not reported in PRESS; only visible in DATA.

## Timing
- Reset values (cycle after CLR sampled high): SR_LD_N=1, SR_CLK=0, DATA=0, PRESS=0, VALID=0, state IDLE, all counters 0. CLR mid-frame aborts immediately; no VALID for the aborted frame.
- After CLR deasserts, first tick DIV cycles later.
- Frame: LOAD 1 tick + NBITS×2 ticks shifting = (1+2·NBITS)·DIV cycles, then DONE 1 cycle.
- Each SR_DIN sample is taken ≥ DIV cycles after the preceding SR_LD_N rise or SR_CLK rise (data settled).
- VALID asserts the cycle after the final HIGH→DONE tick; DATA/PRESS change on the same edge VALID rises, stable until next VALID.
- Frame period with EN held high: (GAP + 1 + 2·NBITS)·DIV cycles + tick-phase alignment of DONE (≤ DIV cycles).
- GAP=0: LOAD begins on the first tick after DONE.

## Test plan
- Reset: CLR high 5 cycles with SR_DIN toggling -> SR_LD_N=1, SR_CLK=0, DATA=0, PRESS=0, VALID=0 throughout.
- DIV=4, NBITS=8, INVERT=0, 165 model loaded with 8'hA5, EN=1 -> SR_LD_N low exactly 4 cycles, exactly 8 SR_CLK rises, DATA=8'hA5, VALID high 1 cycle, PRESS=8'hA5.
- INVERT=1, model inputs 8'hFE for two frames -> frame 1: DATA=8'h01, PRESS=8'h01; frame 2: DATA=8'h01, PRESS=8'h00.
- INVERT=0, inputs 8'h00 → 8'h81 → 8'h01 on successive frames -> PRESS 8'h00, 8'h81, 8'h00; DATA 8'h00, 8'h81, 8'h01.
- EN dropped during 3rd LOW phase -> frame completes, VALID pulses once, then SR_LD_N stays 1 and SR_CLK stays 0 for ≥ 4 frame periods; EN re-raised -> LOAD on a tick after gap satisfied.
- CLR pulsed 1 cycle during 5th HIGH phase -> next cycle all outputs at reset values, no VALID; next frame starts with full LOAD and returns correct 8'hA5.
